// File: rtl/shift_unit_pkg.sv
// Shared types for the pipelined shift/rotate unit.
//   shift_mode_e : operation select carried on in_mode (codes 5..7 are reserved
//                  and pass the operand through unchanged).
package shift_unit_pkg;

  localparam int unsigned SHIFT_MODE_W = 3;

  typedef enum logic [SHIFT_MODE_W-1:0] {
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROL,
    SH_ROR
  } shift_mode_e;

endpackage

// File: rtl/shift_funnel_level.sv
// One registered level of the funnel shifter.
// Conditionally shifts the 2*WIDTH funnel word right by DIST when the matching
// bit of the right-shift count m is set, then registers the word, the count and
// the valid bit. All state holds while en is low.
// Optional carry bit (SHIFT_UNIT_CARRY_EN) travels alongside unchanged.
// Ports:
//   clk, rst             clock, async active-high reset
//   en                   load enable (global pipeline advance)
//   in_valid/out_valid   stage valid bit
//   in_word/out_word     2*WIDTH funnel word
//   in_m/out_m           right-shift count, LOG2W bits
//   in_carry/out_carry   last bit shifted out (SHIFT_UNIT_CARRY_EN only)
module shift_funnel_level #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DIST  = 1,
  localparam int unsigned LOG2W = $clog2(WIDTH),
  localparam int unsigned MBIT  = $clog2(DIST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] in_word,
  input  logic [LOG2W-1:0]   in_m,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_word,
  output logic [LOG2W-1:0]   out_m
`ifdef SHIFT_UNIT_CARRY_EN
  ,
  input  logic               in_carry,
  output logic               out_carry
`endif
);

  logic [2*WIDTH-1:0] word_d;

  // This level owns count bit MBIT, i.e. a shift of DIST = 2^MBIT.
  assign word_d = in_m[MBIT] ? (in_word >> DIST) : in_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_m     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_word  <= word_d;
      out_m     <= in_m;
    end
  end

`ifdef SHIFT_UNIT_CARRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_carry <= 1'b0;
    end else if (en) begin
      out_carry <= in_carry;
    end
  end
`endif

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined shift/rotate unit with valid/ready handshake on both sides.
// Stage 0 builds a 2*WIDTH funnel word {hi,lo} and a right-shift count m from
// the operand, amount and mode; LOG2W funnel levels then shift right by powers
// of two. Result is the low WIDTH bits of the last level, LAT cycles after accept.
// A single advance signal stalls the whole pipe when the output is held.
// Optional feature macro: SHIFT_UNIT_CARRY_EN adds out_carry (last bit shifted out).
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid, in_ready    input handshake (in_ready = !out_valid | out_ready)
//   in_data [WIDTH]       operand
//   in_amt  [SHW]         shift amount, 0..2*WIDTH-1
//   in_mode [3]           shift_mode_e
//   out_valid, out_ready  output handshake
//   out_data [WIDTH]      result
//   out_carry             last bit shifted out (SHIFT_UNIT_CARRY_EN only)
module shift_unit_pipe
  import shift_unit_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned LOG2W = $clog2(WIDTH),
  localparam int unsigned SHW   = LOG2W + 1,
  localparam int unsigned LAT   = LOG2W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SHW-1:0]          in_amt,
  input  logic [SHIFT_MODE_W-1:0] in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef SHIFT_UNIT_CARRY_EN
  ,
  output logic                    out_carry
`endif
);

  logic               adv;
  logic [LOG2W-1:0]   n_lo;
  logic [LOG2W-1:0]   n_neg;
  logic               sat;
  logic               amt_zero;
  logic               sign;

  logic [2*WIDTH-1:0] s0_word_d;
  logic [2*WIDTH-1:0] s0_word_q;
  logic [LOG2W-1:0]   s0_m_d;
  logic [LOG2W-1:0]   s0_m_q;
  logic               s0_valid_q;

  // Per-stage view of the pipe: index 0 is stage 0, LAT-1 is the output stage.
  logic [2*WIDTH-1:0] word_s  [LAT];
  logic [LOG2W-1:0]   m_s     [LAT];
  logic               valid_s [LAT];

  // Global stall: everything moves only when the output slot is free or draining.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Amount decode: n >= WIDTH is flagged by the top amount bit.
  assign n_lo     = in_amt[LOG2W-1:0];
  assign n_neg    = LOG2W'(0) - n_lo;
  assign sat      = in_amt[SHW-1];
  assign amt_zero = (in_amt == '0);
  assign sign     = in_data[WIDTH-1];

  // Funnel word and right-shift count. Saturated cases are pre-resolved into
  // the word with m=0 so the levels never see an out-of-range count.
  always_comb begin
    s0_word_d = {{WIDTH{1'b0}}, in_data};
    s0_m_d    = '0;
    if (!amt_zero) begin
      case (in_mode)
        SH_LSL: begin
          if (sat) begin
            s0_word_d = '0;
          end else begin
            s0_word_d = {in_data, {WIDTH{1'b0}}};
            s0_m_d    = n_neg;
          end
        end
        SH_LSR: begin
          if (sat) begin
            s0_word_d = '0;
          end else begin
            s0_m_d = n_lo;
          end
        end
        SH_ASR: begin
          if (sat) begin
            s0_word_d = {(2*WIDTH){sign}};
          end else begin
            s0_word_d = {{WIDTH{sign}}, in_data};
            s0_m_d    = n_lo;
          end
        end
        SH_ROL: begin
          s0_word_d = {in_data, in_data};
          s0_m_d    = n_neg;
        end
        SH_ROR: begin
          s0_word_d = {in_data, in_data};
          s0_m_d    = n_lo;
        end
        default: ;
      endcase
    end
  end

  // Stage 0 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_word_q  <= '0;
      s0_m_q     <= '0;
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_word_q  <= s0_word_d;
      s0_m_q     <= s0_m_d;
    end
  end

  assign valid_s[0] = s0_valid_q;
  assign word_s[0]  = s0_word_q;
  assign m_s[0]     = s0_m_q;

`ifdef SHIFT_UNIT_CARRY_EN
  logic [LOG2W-1:0] n_dec;
  logic             amt_at_w;
  logic             s0_carry_d;
  logic             s0_carry_q;
  logic             carry_s [LAT];

  assign n_dec    = n_lo - LOG2W'(1);
  assign amt_at_w = (in_amt == SHW'(WIDTH));

  // Last bit shifted out, taken straight from the operand.
  // n_neg indexes op[W-n] (LSL, ROL -> result[0]); n_dec indexes op[n-1]
  // (LSR, ASR, ROR -> result[W-1]). Both wrap correctly at n = WIDTH.
  always_comb begin
    s0_carry_d = 1'b0;
    if (!amt_zero) begin
      case (in_mode)
        SH_LSL:  s0_carry_d = (!sat || amt_at_w) ? in_data[n_neg] : 1'b0;
        SH_LSR:  s0_carry_d = (!sat || amt_at_w) ? in_data[n_dec] : 1'b0;
        SH_ASR:  s0_carry_d = sat ? sign : in_data[n_dec];
        SH_ROL:  s0_carry_d = in_data[n_neg];
        SH_ROR:  s0_carry_d = in_data[n_dec];
        default: s0_carry_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_carry_q <= 1'b0;
    end else if (adv) begin
      s0_carry_q <= s0_carry_d;
    end
  end

  assign carry_s[0] = s0_carry_q;
  assign out_carry  = carry_s[LAT-1];
`endif

  // Funnel levels 1..LOG2W; level k shifts by 2^(k-1).
  for (genvar k = 1; k < LAT; k++) begin : g_level
    shift_funnel_level #(
      .WIDTH (WIDTH),
      .DIST  (2 ** (k - 1))
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (valid_s[k-1]),
      .in_word   (word_s[k-1]),
      .in_m      (m_s[k-1]),
      .out_valid (valid_s[k]),
      .out_word  (word_s[k]),
      .out_m     (m_s[k])
`ifdef SHIFT_UNIT_CARRY_EN
      ,
      .in_carry  (carry_s[k-1]),
      .out_carry (carry_s[k])
`endif
    );
  end

  assign out_valid = valid_s[LAT-1];
  assign out_data  = word_s[LAT-1][WIDTH-1:0];

  // Upper funnel half and count of the last level are never consumed.
  logic unused_tail;
  assign unused_tail = ^{word_s[LAT-1][2*WIDTH-1:WIDTH], m_s[LAT-1]};

endmodule
